// File: rtl/user_power_pkg.sv
// rtl/user_power_pkg.sv - shared state type, step order and width helpers for the user power sequencer
package user_power_pkg;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_UP_CLK,
        ST_UP_WB,
        ST_UP_LA,
        ST_UP_IRQ,
        ST_ON,
        ST_DN_IRQ,
        ST_DN_LA,
        ST_DN_WB,
        ST_DN_CLK
    } seq_state_e;

    // Enable bit positions, numbered in power-up order (power-down walks them backwards)
    localparam logic [1:0] EN_CLK = 2'd0;
    localparam logic [1:0] EN_WB  = 2'd1;
    localparam logic [1:0] EN_LA  = 2'd2;
    localparam logic [1:0] EN_IRQ = 2'd3;
    localparam int         N_EN   = 4;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_STEP_CYCLES     = 4;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] en_bit(input seq_state_e s);
        case (s)
            ST_UP_WB,  ST_DN_WB:  return EN_WB;
            ST_UP_LA,  ST_DN_LA:  return EN_LA;
            ST_UP_IRQ, ST_DN_IRQ: return EN_IRQ;
            default:              return EN_CLK;
        endcase
    endfunction

    function automatic seq_state_e up_next(input seq_state_e s);
        case (s)
            ST_UP_CLK: return ST_UP_WB;
            ST_UP_WB:  return ST_UP_LA;
            ST_UP_LA:  return ST_UP_IRQ;
            default:   return ST_ON;
        endcase
    endfunction

    function automatic seq_state_e dn_next(input seq_state_e s);
        case (s)
            ST_DN_IRQ: return ST_DN_LA;
            ST_DN_LA:  return ST_DN_WB;
            ST_DN_WB:  return ST_DN_CLK;
            default:   return ST_OFF;
        endcase
    endfunction

    // An aborted power-up enters the DN step matching the highest enable already raised
    function automatic seq_state_e up_to_dn(input seq_state_e s);
        case (s)
            ST_UP_CLK: return ST_DN_CLK;
            ST_UP_WB:  return ST_DN_WB;
            ST_UP_LA:  return ST_DN_LA;
            default:   return ST_DN_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/pg_sync_debounce.sv
// rtl/pg_sync_debounce.sv - 2-flop synchronizer and debounce counter for one tie-high input
module pg_sync_debounce
    import user_power_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_pg
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_pg;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_pg  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            if (!r_s2) begin
                r_cnt <= '0;
                r_pg  <= 1'b0;
            end else if (r_cnt == CNT_LAST) begin
                r_pg <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sync = r_s2;
    assign o_pg   = r_pg;

endmodule

// File: rtl/user_power_sequencer.sv
// rtl/user_power_sequencer.sv - debounces user-domain tie-highs and sequences user-interface enables
module user_power_sequencer
    import user_power_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STEP_CYCLES     = DEF_STEP_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             mprj_vdd_logic1,
    input  logic             mprj2_vdd_logic1,
    input  logic             seq_enable,
    input  logic             loss_cnt_clr,
    output logic             user1_powergood,
    output logic             user2_powergood,
    output logic             user_clock_en,
    output logic             wb_en,
    output logic             la_en,
    output logic             irq_en,
    output logic             seq_busy,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int                STEP_W    = cnt_width(STEP_CYCLES);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    logic              w_u1_sync;
    logic              w_u1_pg;
    logic              w_unused_u2_sync;
    logic              w_u2_pg;
    seq_state_e        r_state;
    seq_state_e        w_next_state;
    logic [N_EN-1:0]   r_en;
    logic [N_EN-1:0]   w_next_en;
    logic [STEP_W-1:0] r_step;
    logic [CNT_W-1:0]  r_loss_cnt;
    logic              w_step_done;
    logic              w_busy;
    logic              w_power_lost;
    logic              w_loss_event;

    pg_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pg_user1 (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_async (mprj_vdd_logic1),
        .o_sync  (w_u1_sync),
        .o_pg    (w_u1_pg)
    );

    pg_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pg_user2 (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_async (mprj2_vdd_logic1),
        .o_sync  (w_unused_u2_sync),
        .o_pg    (w_u2_pg)
    );

    assign w_busy       = (r_state != ST_OFF) && (r_state != ST_ON);
    assign w_step_done  = (r_step == STEP_LAST);
    // Acts on the same edge at which the user1 flag drops, so both clear together
    assign w_power_lost = (r_state != ST_OFF) && !w_u1_sync;
    assign w_loss_event = w_power_lost && (|r_en);

    always_comb begin
        w_next_state = r_state;
        w_next_en    = r_en;
        if (w_power_lost) begin
            w_next_state = ST_OFF;
            w_next_en    = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (w_u1_pg && w_u1_sync && seq_enable) begin
                        w_next_state      = ST_UP_CLK;
                        w_next_en[EN_CLK] = 1'b1;
                    end
                end
                ST_UP_CLK, ST_UP_WB, ST_UP_LA, ST_UP_IRQ: begin
                    if (!seq_enable) begin
                        w_next_state               = up_to_dn(r_state);
                        w_next_en[en_bit(r_state)] = 1'b0;
                    end else if (w_step_done) begin
                        w_next_state = up_next(r_state);
                        if (w_next_state != ST_ON) begin
                            w_next_en[en_bit(w_next_state)] = 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    if (!seq_enable) begin
                        w_next_state      = ST_DN_IRQ;
                        w_next_en[EN_IRQ] = 1'b0;
                    end
                end
                default: begin
                    if (w_step_done) begin
                        w_next_state = dn_next(r_state);
                        if (w_next_state != ST_OFF) begin
                            w_next_en[en_bit(w_next_state)] = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_OFF;
            r_en    <= '0;
        end else begin
            r_state <= w_next_state;
            r_en    <= w_next_en;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_step <= '0;
        end else if ((w_next_state != r_state) || !w_busy) begin
            r_step <= '0;
        end else if (!w_step_done) begin
            r_step <= r_step + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_loss_cnt <= '0;
        end else if (w_loss_event) begin
            if (loss_cnt_clr) begin
                r_loss_cnt <= CNT_W'(1);
            end else if (r_loss_cnt != '1) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
            end
        end else if (loss_cnt_clr) begin
            r_loss_cnt <= '0;
        end
    end

    assign user1_powergood = w_u1_pg;
    assign user2_powergood = w_u2_pg;
    assign user_clock_en   = r_en[EN_CLK];
    assign wb_en           = r_en[EN_WB];
    assign la_en           = r_en[EN_LA];
    assign irq_en          = r_en[EN_IRQ];
    assign seq_busy        = w_busy;
    assign loss_cnt        = r_loss_cnt;

endmodule

// File: tb/tb_user_power_sequencer.sv
// tb/tb_user_power_sequencer.sv - directed bench for user_power_sequencer (DEBOUNCE_CYCLES=16, STEP_CYCLES=4)
module tb_user_power_sequencer;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       mprj_vdd_logic1 = 1'b0;
    logic       mprj2_vdd_logic1 = 1'b0;
    logic       seq_enable = 1'b0;
    logic       loss_cnt_clr = 1'b0;
    logic       user1_powergood;
    logic       user2_powergood;
    logic       user_clock_en;
    logic       wb_en;
    logic       la_en;
    logic       irq_en;
    logic       seq_busy;
    logic [7:0] loss_cnt;
    logic [3:0] en;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    user_power_sequencer #(
        .DEBOUNCE_CYCLES (16),
        .STEP_CYCLES     (4),
        .CNT_W           (8)
    ) dut (
        .wb_clk_i         (wb_clk_i),
        .wb_rst_i         (wb_rst_i),
        .mprj_vdd_logic1  (mprj_vdd_logic1),
        .mprj2_vdd_logic1 (mprj2_vdd_logic1),
        .seq_enable       (seq_enable),
        .loss_cnt_clr     (loss_cnt_clr),
        .user1_powergood  (user1_powergood),
        .user2_powergood  (user2_powergood),
        .user_clock_en    (user_clock_en),
        .wb_en            (wb_en),
        .la_en            (la_en),
        .irq_en           (irq_en),
        .seq_busy         (seq_busy),
        .loss_cnt         (loss_cnt)
    );

    assign en = {irq_en, la_en, wb_en, user_clock_en};

    always #5 wb_clk_i = ~wb_clk_i;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Returns at the falling edge following rising edge number c
    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge wb_clk_i);
    endtask

    task automatic wait_clk_en(output int at);
        int t;
        t = 0;
        while (!user_clock_en && t < 40) begin
            @(negedge wb_clk_i);
            t++;
        end
        chk("clk_en_wait", user_clock_en, 1);
        at = cyc;
    endtask

    initial begin
        int x;

        wait_cyc(2);
        chk("rst_pg1", user1_powergood, 0);
        chk("rst_pg2", user2_powergood, 0);
        chk("rst_en", en, 4'b0000);
        chk("rst_busy", seq_busy, 0);
        chk("rst_cnt", loss_cnt, 0);
        wait_cyc(3);
        wb_rst_i = 1'b0;

        wait_cyc(10);
        mprj_vdd_logic1 = 1'b1;
        mprj2_vdd_logic1 = 1'b1;
        seq_enable = 1'b1;
        wait_cyc(27); chk("up_pg1_27", user1_powergood, 0);
        wait_cyc(28); chk("up_pg1_28", user1_powergood, 1);
                      chk("up_pg2_28", user2_powergood, 1);
                      chk("up_en_28", en, 4'b0000);
        wait_cyc(29); chk("up_en_29", en, 4'b0001);
                      chk("up_busy_29", seq_busy, 1);
        wait_cyc(32); chk("up_en_32", en, 4'b0001);
        wait_cyc(33); chk("up_en_33", en, 4'b0011);
        wait_cyc(36); chk("up_en_36", en, 4'b0011);
        wait_cyc(37); chk("up_en_37", en, 4'b0111);
        wait_cyc(40); chk("up_en_40", en, 4'b0111);
        wait_cyc(41); chk("up_en_41", en, 4'b1111);
        wait_cyc(44); chk("up_busy_44", seq_busy, 1);
        wait_cyc(45); chk("up_busy_45", seq_busy, 0);

        wait_cyc(100);
        mprj_vdd_logic1 = 1'b0;
        wait_cyc(102); chk("loss_pg1_102", user1_powergood, 1);
                       chk("loss_en_102", en, 4'b1111);
        wait_cyc(103); chk("loss_pg1_103", user1_powergood, 0);
                       chk("loss_en_103", en, 4'b0000);
                       chk("loss_cnt_103", loss_cnt, 1);
                       chk("loss_busy_103", seq_busy, 0);

        wait_cyc(139); mprj_vdd_logic1 = 1'b1;
        wait_cyc(149); mprj_vdd_logic1 = 1'b0;
        wait_cyc(150); mprj_vdd_logic1 = 1'b1;
                       mprj2_vdd_logic1 = 1'b0;
        wait_cyc(152); chk("u2_pg_152", user2_powergood, 1);
        wait_cyc(153); chk("u2_pg_153", user2_powergood, 0);
        wait_cyc(157); chk("gl_pg1_157", user1_powergood, 0);
        wait_cyc(167); chk("gl_pg1_167", user1_powergood, 0);
        wait_cyc(168); chk("gl_pg1_168", user1_powergood, 1);
                       chk("gl_en_168", en, 4'b0000);
        wait_cyc(169); chk("gl_en_169", en, 4'b0001);
                       chk("gl_pg2_169", user2_powergood, 0);
        wait_cyc(185); chk("gl_en_185", en, 4'b1111);
                       chk("gl_busy_185", seq_busy, 0);

        wait_cyc(200); chk("dn_en_200", en, 4'b1111);
        seq_enable = 1'b0;
        wait_cyc(201); chk("dn_en_201", en, 4'b0111);
                       chk("dn_busy_201", seq_busy, 1);
        wait_cyc(204); chk("dn_en_204", en, 4'b0111);
        wait_cyc(205); chk("dn_en_205", en, 4'b0011);
        wait_cyc(209); chk("dn_en_209", en, 4'b0001);
        wait_cyc(212); chk("dn_en_212", en, 4'b0001);
        wait_cyc(213); chk("dn_en_213", en, 4'b0000);
                       chk("dn_pg1_213", user1_powergood, 1);
        wait_cyc(216); chk("dn_busy_216", seq_busy, 1);
        wait_cyc(217); chk("dn_busy_217", seq_busy, 0);
                       chk("dn_cnt_217", loss_cnt, 1);

        wait_cyc(220); seq_enable = 1'b1;
        wait_cyc(221); chk("ab_en_221", en, 4'b0001);
        wait_cyc(225); chk("ab_en_225", en, 4'b0011);
        wait_cyc(227); chk("ab_en_227", en, 4'b0011);
        seq_enable = 1'b0;
        wait_cyc(228); chk("ab_en_228", en, 4'b0001);
        wait_cyc(229); chk("ab_en_229", en, 4'b0001);
        wait_cyc(231); chk("ab_en_231", en, 4'b0001);
        wait_cyc(232); chk("ab_en_232", en, 4'b0000);
        wait_cyc(235); chk("ab_busy_235", seq_busy, 1);
        wait_cyc(236); chk("ab_busy_236", seq_busy, 0);
                       chk("ab_en_236", en, 4'b0000);

        wait_cyc(240); seq_enable = 1'b1;
        wait_cyc(245); chk("rs_en_245", en, 4'b0011);
        wait_cyc(246); wb_rst_i = 1'b1;
        wait_cyc(247); chk("rs_en_247", en, 4'b0000);
                       chk("rs_pg1_247", user1_powergood, 0);
                       chk("rs_busy_247", seq_busy, 0);
                       chk("rs_cnt_247", loss_cnt, 0);
        wait_cyc(248); wb_rst_i = 1'b0;

        for (int i = 1; i <= 256; i++) begin
            seq_enable = 1'b1;
            mprj_vdd_logic1 = 1'b1;
            wait_clk_en(x);
            mprj_vdd_logic1 = 1'b0;
            wait_cyc(x + 4);
            if (i == 255) chk("sat_cnt_255", loss_cnt, 255);
            if (i == 256) chk("sat_cnt_256", loss_cnt, 255);
        end

        mprj_vdd_logic1 = 1'b1;
        wait_clk_en(x);
        mprj_vdd_logic1 = 1'b0;
        wait_cyc(x + 2); loss_cnt_clr = 1'b1;
        wait_cyc(x + 3); loss_cnt_clr = 1'b0;
        chk("clr_loss_cnt", loss_cnt, 1);
        chk("clr_loss_en", en, 4'b0000);
        wait_cyc(x + 4); loss_cnt_clr = 1'b1;
        wait_cyc(x + 5); loss_cnt_clr = 1'b0;
        chk("clr_only_cnt", loss_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
